// File: rtl/ame_sobel_pkg.sv
// ----------------------------------------------------------------------------
// Module   : ame_sobel_pkg
// Brief    : Shared constants, types and width helper for the AME Sobel engine.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

package ame_sobel_pkg;

    localparam int NUM_LINES     = 6;
    localparam int OUT_DIM       = 4;
    localparam int LINE_BITS_DEF = 7;
    localparam int COMP_BITS_DEF = 8;

    // Signed gradient width: 4x pixel range on each side plus a sign bit.
    function automatic int grad_width(input int line_bits);
        return line_bits + 3;
    endfunction

    typedef logic [NUM_LINES-1:0][LINE_BITS_DEF-1:0]              line_t;
    typedef logic [OUT_DIM-1:0][OUT_DIM-1:0][COMP_BITS_DEF-1:0]   result_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOAD = 1'b1
    } state_e;

endpackage

`default_nettype wire

// File: rtl/ame_sobel_col.sv
// ----------------------------------------------------------------------------
// Module   : ame_sobel_col
// Brief    : Combinational 4-row Sobel column (right line minus left line),
//            absolute value, then saturate (AME_SOBEL_SAT_EN) or truncate.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module ame_sobel_col
    import ame_sobel_pkg::*;
#(
    parameter int LINE_DATA_BITS = 7,
    parameter int COMP_DATA_BITS = 8
) (
    input  logic [NUM_LINES-1:0][LINE_DATA_BITS-1:0] left_i,
    input  logic [NUM_LINES-1:0][LINE_DATA_BITS-1:0] right_i,
    output logic [OUT_DIM-1:0][COMP_DATA_BITS-1:0]   mag_o
);

    localparam int GRAD_W = grad_width(LINE_DATA_BITS);
    localparam int MAG_W  = GRAD_W - 1;

    for (genvar y = 0; y < OUT_DIM; y++) begin : g_row
        logic signed [GRAD_W-1:0] w_sum_l;
        logic signed [GRAD_W-1:0] w_sum_r;
        logic signed [GRAD_W-1:0] w_grad;
        logic        [MAG_W-1:0]  w_abs;

        assign w_sum_l = GRAD_W'(left_i[y]) + (GRAD_W'(left_i[y+1]) << 1) + GRAD_W'(left_i[y+2]);
        assign w_sum_r = GRAD_W'(right_i[y]) + (GRAD_W'(right_i[y+1]) << 1) + GRAD_W'(right_i[y+2]);
        assign w_grad  = w_sum_r - w_sum_l;
        assign w_abs   = w_grad[GRAD_W-1] ? MAG_W'(-w_grad) : MAG_W'(w_grad);

        if (MAG_W > COMP_DATA_BITS) begin : g_narrow
`ifdef AME_SOBEL_SAT_EN
            assign mag_o[y] = (|w_abs[MAG_W-1:COMP_DATA_BITS]) ? {COMP_DATA_BITS{1'b1}}
                                                               : w_abs[COMP_DATA_BITS-1:0];
`else
            assign mag_o[y] = COMP_DATA_BITS'(w_abs);
`endif
        end else begin : g_wide
            assign mag_o[y] = COMP_DATA_BITS'(w_abs);
        end
    end

endmodule

`default_nettype wire

// File: rtl/ame_sobel_filter_4x4.sv
// ----------------------------------------------------------------------------
// Module   : ame_sobel_filter_4x4
// Brief    : Streams six 6-pixel lines and produces a 4x4 Sobel magnitude tile.
//            Optional macro AME_SOBEL_SAT_EN selects saturation over wrap-around.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module ame_sobel_filter_4x4
    import ame_sobel_pkg::*;
#(
    parameter int LINE_DATA_BITS = 7,
    parameter int COMP_DATA_BITS = 8
) (
    input  logic                                                clk_i,
    input  logic                                                rst_n_i,
    input  logic                                                comp_init_i,
    output logic                                                comp_done_o,
    input  logic [NUM_LINES-1:0][LINE_DATA_BITS-1:0]            line_data_i,
    output logic [OUT_DIM-1:0][OUT_DIM-1:0][COMP_DATA_BITS-1:0] comp_data_o
);

    localparam logic [2:0] LAST_LINE = 3'(NUM_LINES - 1);

    state_e                                              state_q, state_d;
    logic [2:0]                                          cnt_q, cnt_d;
    logic [NUM_LINES-1:0][LINE_DATA_BITS-1:0]            prev1_q, prev1_d;
    logic [NUM_LINES-1:0][LINE_DATA_BITS-1:0]            prev2_q, prev2_d;
    logic [OUT_DIM-1:0][OUT_DIM-1:0][COMP_DATA_BITS-1:0] data_q, data_d;
    logic                                                done_q, done_d;

    logic [OUT_DIM-1:0][COMP_DATA_BITS-1:0]              w_mag;
    logic [1:0]                                          w_col;

    // One column engine, shared: at line k it pairs stored L[k-2] with live L[k].
    ame_sobel_col #(
        .LINE_DATA_BITS (LINE_DATA_BITS),
        .COMP_DATA_BITS (COMP_DATA_BITS)
    ) u_col (
        .left_i  (prev2_q),
        .right_i (line_data_i),
        .mag_o   (w_mag)
    );

    assign w_col = 2'(cnt_q - 3'd2);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prev1_d = prev1_q;
        prev2_d = prev2_q;
        data_d  = data_q;
        done_d  = 1'b0;

        // Init has priority, even over the final line of a running tile.
        if (comp_init_i) begin
            state_d = ST_LOAD;
            cnt_d   = 3'd1;
            prev2_d = prev1_q;
            prev1_d = line_data_i;
        end else if (state_q == ST_LOAD) begin
            prev2_d = prev1_q;
            prev1_d = line_data_i;
            if (cnt_q >= 3'd2) begin
                data_d[w_col] = w_mag;
            end
            if (cnt_q == LAST_LINE) begin
                state_d = ST_IDLE;
                cnt_d   = 3'd0;
                done_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            prev1_q <= '0;
            prev2_q <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prev1_q <= prev1_d;
            prev2_q <= prev2_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    assign comp_done_o = done_q;
    assign comp_data_o = data_q;

endmodule

`default_nettype wire

// File: tb/tb_ame_sobel_filter_4x4.sv
// ----------------------------------------------------------------------------
// Module   : tb_ame_sobel_filter_4x4
// Brief    : Directed self-checking bench for ame_sobel_filter_4x4.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_ame_sobel_filter_4x4;
    import ame_sobel_pkg::*;

`ifdef AME_SOBEL_SAT_EN
    localparam int EXP508 = 255;
    localparam int EXP400 = 255;
`else
    localparam int EXP508 = 252;
    localparam int EXP400 = 144;
`endif

    logic    clk;
    logic    rst_n;
    logic    comp_init;
    logic    comp_done;
    line_t   line_data;
    result_t comp_data;

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;

    ame_sobel_filter_4x4 #(
        .LINE_DATA_BITS (7),
        .COMP_DATA_BITS (8)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .comp_init_i (comp_init),
        .comp_done_o (comp_done),
        .line_data_i (line_data),
        .comp_data_o (comp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (comp_done) done_cnt++;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step(input logic init, input line_t l);
        @(negedge clk);
        comp_init = init;
        line_data = l;
        @(posedge clk);
        #1;
    endtask

    function automatic line_t uni(input int v);
        line_t l;
        for (int p = 0; p < NUM_LINES; p++) l[p] = 7'(v);
        return l;
    endfunction

    function automatic line_t slope(input int k);
        line_t l;
        for (int p = 0; p < NUM_LINES; p++) l[p] = 7'(p * k);
        return l;
    endfunction

    task automatic check_cols(input string tag, input int e0, input int e1, input int e2, input int e3);
        int e[4];
        e = '{e0, e1, e2, e3};
        for (int x = 0; x < OUT_DIM; x++)
            for (int y = 0; y < OUT_DIM; y++)
                check_eq($sformatf("%s_x%0dy%0d", tag, x, y), int'(comp_data[x][y]), e[x]);
    endtask

    task automatic run_tile(input string tag, input line_t ls[6]);
        for (int k = 0; k < NUM_LINES; k++) begin
            step(k == 0, ls[k]);
            check_eq($sformatf("%s_done_k%0d", tag, k), int'(comp_done), (k == 5) ? 1 : 0);
        end
    endtask

    initial begin
        line_t ls[6];
        int d0;

        rst_n     = 1'b0;
        comp_init = 1'b0;
        line_data = '0;
        step(1'b0, uni(0));
        step(1'b0, uni(0));
        check_eq("rst_done", int'(comp_done), 0);
        check_cols("rst", 0, 0, 0, 0);
        rst_n = 1'b1;
        step(1'b0, uni(0));

        // Flat tile, then idle: done drops, outputs hold.
        for (int k = 0; k < 6; k++) ls[k] = uni(50);
        run_tile("flat", ls);
        check_cols("flat", 0, 0, 0, 0);
        step(1'b0, uni(0));
        check_eq("flat_idle_done", int'(comp_done), 0);

        for (int k = 0; k < 6; k++) ls[k] = uni(10 * k);
        run_tile("ramp", ls);
        check_cols("ramp", 80, 80, 80, 80);
        step(1'b0, uni(0));

        // Per-row variation: G[x][y] = 8*(y+1).
        for (int k = 0; k < 6; k++) ls[k] = slope(k);
        run_tile("slope", ls);
        for (int x = 0; x < OUT_DIM; x++)
            for (int y = 0; y < OUT_DIM; y++)
                check_eq($sformatf("slope_x%0dy%0d", x, y), int'(comp_data[x][y]), 8 * (y + 1));

        // Max step, started back-to-back in the done cycle of the slope tile.
        for (int k = 0; k < 6; k++) ls[k] = uni(k < 3 ? 0 : 127);
        run_tile("maxstep", ls);
        check_cols("maxstep", 0, EXP508, EXP508, 0);
        step(1'b0, uni(0));

        // Restart after three lines: only the second tile completes.
        d0 = done_cnt;
        step(1'b1, uni(100));
        step(1'b0, uni(0));
        step(1'b0, uni(0));
        step(1'b1, uni(50));
        for (int k = 1; k < 6; k++) begin
            step(1'b0, uni(50));
            check_eq($sformatf("restart_done_k%0d", k), int'(comp_done), (k == 5) ? 1 : 0);
        end
        check_cols("restart", 0, 0, 0, 0);
        step(1'b0, uni(0));
        check_eq("restart_pulses", done_cnt - d0, 1);

        // Init on the final line of a tile suppresses its done; then negative tile.
        for (int k = 0; k < 5; k++) step(k == 0, uni(0));
        step(1'b1, uni(100));
        check_eq("init_at_e5_done", int'(comp_done), 0);
        for (int k = 1; k < 6; k++) begin
            step(1'b0, uni(0));
            check_eq($sformatf("neg_done_k%0d", k), int'(comp_done), (k == 5) ? 1 : 0);
        end
        check_cols("neg", EXP400, 0, 0, 0);
        step(1'b0, uni(0));

        // Reset at E3 aborts the tile.
        d0 = done_cnt;
        step(1'b1, uni(0));
        step(1'b0, uni(10));
        step(1'b0, uni(20));
        check_eq("abort_col0", int'(comp_data[0][0]), 80);
        rst_n = 1'b0;
        step(1'b0, uni(30));
        check_eq("abort_done", int'(comp_done), 0);
        check_cols("abort", 0, 0, 0, 0);
        rst_n = 1'b1;
        step(1'b0, uni(40));
        step(1'b0, uni(50));
        step(1'b0, uni(0));
        check_eq("abort_pulses", done_cnt - d0, 0);

        for (int k = 0; k < 6; k++) ls[k] = uni(10 * k);
        run_tile("fresh", ls);
        check_cols("fresh", 80, 80, 80, 80);
        step(1'b0, uni(0));
        check_eq("fresh_idle_done", int'(comp_done), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
